// File: rtl/digit_scan_ctrl.sv
// Multiplexed display scan controller: drives a 2-to-4 digit decoder with a
// dwell/blank timed enable, skipping masked-off digits and flagging frame starts.
module digit_scan_ctrl #(
    parameter int unsigned DWELL = 50000,
    parameter int unsigned BLANK = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] mask,
    output logic       en,
    output logic [1:0] a,
    output logic       frame
);

    localparam int unsigned CW = 20;
    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LD = (BLANK > 0) ? CW'(BLANK - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q, en_d;
    logic [1:0]    a_q, a_d;
    logic          frame_q, frame_d;
    logic          advance;
    logic [1:0]    aNext;

    function automatic logic [1:0] lowestIdx(input logic [3:0] m);
        logic [1:0] res;
        res = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) res = 2'(i);
        end
        return res;
    endfunction

    // Circular search after cur; offset 4 wraps back onto cur itself and is
    // checked first so that any nearer set bit overrides it.
    function automatic logic [1:0] nextIdx(input logic [1:0] cur, input logic [3:0] m);
        logic [1:0] res;
        logic [1:0] idx;
        res = cur;
        for (int i = 4; i >= 1; i--) begin
            idx = cur + 2'(i);
            if (m[idx]) res = idx;
        end
        return res;
    endfunction

    assign aNext = nextIdx(a_q, mask);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        frame_d = 1'b0;
        advance = 1'b0;

        case (state_q)
            IDLE: begin
                if (run && (mask != 4'd0)) begin
                    state_d = SHOW;
                    cnt_d   = DWELL_LD;
                    a_d     = lowestIdx(mask);
                end
            end
            SHOW: begin
                if (!run) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    if (BLANK > 0) begin
                        state_d = GAP;
                        cnt_d   = BLANK_LD;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (!run) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (advance) begin
            if (mask == 4'd0) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = SHOW;
                cnt_d   = DWELL_LD;
                a_d     = aNext;
                frame_d = (aNext <= a_q);
            end
        end

        en_d = (state_d == SHOW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            a_q     <= 2'b00;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            a_q     <= a_d;
            frame_q <= frame_d;
        end
    end

    assign en    = en_q;
    assign a     = a_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl: one instance with a blank gap, one
// without; per-cycle expectations are queued by stimulus and checked by a monitor.
module tb_digit_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       run0, run1;
    logic [3:0] mask0, mask1;
    logic       en0, en1;
    logic [1:0] a0, a1;
    logic       fr0, fr1;

    typedef struct packed {
        logic       sel;
        logic       en;
        logic [1:0] a;
        logic       fr;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    digit_scan_ctrl #(.DWELL(4), .BLANK(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .run(run0), .mask(mask0),
        .en(en0), .a(a0), .frame(fr0)
    );

    digit_scan_ctrl #(.DWELL(4), .BLANK(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .run(run1), .mask(mask1),
        .en(en1), .a(a1), .frame(fr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation per cycle, compared on the falling edge.
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] act;
        cyc++;
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = e.sel ? {en1, a1, fr1} : {en0, a0, fr0};
            total++;
            if (act !== {e.en, e.a, e.fr}) begin
                bad++;
                $display("[TB] FAIL scan cyc=%0d dut%0d got en/a/frame=%b/%0d/%b want %b/%0d/%b",
                         cyc, e.sel, act[3], act[2:1], act[0], e.en, e.a, e.fr);
            end
        end
    end

    // Queue the outputs expected after this rising edge, then set the inputs
    // that the following edge will sample.
    task automatic applyStimulus(input bit sel, input bit expEn, input logic [1:0] expA,
                                 input bit expFr, input bit nRun, input logic [3:0] nMask);
        exp_t e;
        @(posedge clk);
        #1;
        e.sel = sel;
        e.en  = expEn;
        e.a   = expA;
        e.fr  = expFr;
        q.push_back(e);
        if (sel) begin
            run1  = nRun;
            mask1 = nMask;
        end else begin
            run0  = nRun;
            mask0 = nMask;
        end
    endtask

    // Up to four digit slots of DWELL=4 plus blank; aSeq holds each slot's
    // index (slot 0 in the low bits), frSeq marks slots that start with frame.
    task automatic scanCycles(input bit sel, input int n, input logic [7:0] aSeq,
                              input logic [3:0] frSeq, input int blank,
                              input bit r, input logic [3:0] m);
        int period;
        int k;
        int pos;
        period = 4 + blank;
        for (int j = 0; j < n; j++) begin
            k   = j / period;
            pos = j % period;
            applyStimulus(sel, pos < 4, aSeq[2*k +: 2], (pos == 0) && frSeq[k], r, m);
        end
    endtask

    // Reset pulse entirely between two rising edges; the monitor's falling
    // edge sample lands inside the pulse.
    task automatic resetPulse();
        exp_t e;
        @(posedge clk);
        #1;
        e = '{sel: 1'b0, en: 1'b0, a: 2'd0, fr: 1'b0};
        q.push_back(e);
        #2;
        rst_n = 1'b0;
        run0  = 1'b0;
        #4;
        rst_n = 1'b1;
    endtask

    task automatic checkOutput();
        int waitCycles;
        waitCycles = 0;
        while (q.size() > 0 && waitCycles < 10) begin
            @(posedge clk);
            waitCycles++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain got %0d pending want 0", q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        run0  = 1'b0;
        run1  = 1'b0;
        mask0 = 4'd0;
        mask1 = 4'd0;

        applyStimulus(0, 0, 2'd0, 0, 0, 4'd0);
        applyStimulus(0, 0, 2'd0, 0, 0, 4'd0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 2'd0, 0, 1, 4'b1111);

        // Full mask: 0,1,2,3 then wrap to 0 with frame.
        scanCycles(0, 24, 8'b11_10_01_00, 4'b0000, 2, 1, 4'b1111);
        scanCycles(0, 4, 8'b00_00_00_00, 4'b0001, 2, 1, 4'b1111);

        // run drops during the gap; restart picks lowest bit of 1010.
        applyStimulus(0, 0, 2'd0, 0, 0, 4'b1111);
        applyStimulus(0, 0, 2'd0, 0, 0, 4'b1111);
        applyStimulus(0, 0, 2'd0, 0, 1, 4'b1010);
        scanCycles(0, 24, 8'b11_01_11_01, 4'b0100, 2, 1, 4'b1010);

        // mask cleared in the second clock of digit 1: dwell and gap finish.
        applyStimulus(0, 1, 2'd1, 1, 1, 4'b1010);
        applyStimulus(0, 1, 2'd1, 0, 1, 4'b0000);
        applyStimulus(0, 1, 2'd1, 0, 1, 4'b0000);
        applyStimulus(0, 1, 2'd1, 0, 1, 4'b0000);
        applyStimulus(0, 0, 2'd1, 0, 1, 4'b0000);
        applyStimulus(0, 0, 2'd1, 0, 1, 4'b0000);
        applyStimulus(0, 0, 2'd1, 0, 1, 4'b0000);
        applyStimulus(0, 0, 2'd1, 0, 1, 4'b0000);
        applyStimulus(0, 0, 2'd1, 0, 1, 4'b1000);
        applyStimulus(0, 1, 2'd3, 0, 1, 4'b1000);
        applyStimulus(0, 1, 2'd3, 0, 1, 4'b1000);

        // Asynchronous reset mid-show, then a clean restart.
        resetPulse();
        applyStimulus(0, 0, 2'd0, 0, 0, 4'b1000);
        applyStimulus(0, 0, 2'd0, 0, 1, 4'b1000);
        applyStimulus(0, 1, 2'd3, 0, 0, 4'b1000);
        applyStimulus(0, 0, 2'd3, 0, 0, 4'b1000);

        // No blank gap, single digit: en solid, frame every dwell.
        applyStimulus(1, 0, 2'd0, 0, 1, 4'b0100);
        scanCycles(1, 16, 8'b10_10_10_10, 4'b1110, 0, 1, 4'b0100);
        applyStimulus(1, 1, 2'd2, 1, 1, 4'b0100);
        applyStimulus(1, 1, 2'd2, 0, 0, 4'b0100);
        applyStimulus(1, 0, 2'd2, 0, 0, 4'b0100);
        applyStimulus(1, 0, 2'd2, 0, 0, 4'b0100);

        checkOutput();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
